// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, start, 8 data + odd parity + stop, ack).
// Optional single retry on failure when PS2_TX_RETRY_EN is defined.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_nack,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, ACK, FINISH, ERROR, RETRY} state_t;

    state_t        state_q, state_d, fail_st;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall, clk_s, dat_s, tmo;
`ifdef PS2_TX_RETRY_EN
    logic          retry_q, retry_d;
`endif

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
    assign tmo   = cnt_q == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
            data_q     <= 8'h00;
            par_q      <= 1'b0;
            n_q        <= 4'd0;
            cnt_q      <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_data_in};
            data_q     <= data_d;
            par_q      <= par_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        par_d       = par_q;
        n_d         = n_q;
        cnt_d       = cnt_q + 1'b1;
        tx_ready    = 1'b0;
        tx_done     = 1'b0;
        tx_nack     = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
        fail_st     = retry_q ? ERROR : RETRY;
`else
        fail_st     = ERROR;
`endif
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
`ifdef PS2_TX_RETRY_EN
                retry_d  = 1'b0;
`endif
                if (tx_valid) begin
                    data_d  = tx_data;
                    par_d   = ~^tx_data;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    ps2_data_oe = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                ps2_data_oe = 1'b1;
                n_d         = 4'd0;
                state_d     = BITS;
            end
            BITS: begin
                ps2_data_oe = (n_q == 4'd0) ? 1'b1 :
                              (n_q <= 4'd8) ? ~data_q[n_q[2:0] - 3'd1] :
                              (n_q == 4'd9) ? ~par_q : 1'b0;
                // the 11th falling edge carries the device's ack on the data line
                if (fall) begin
                    cnt_d = '0;
                    n_d   = n_q + 4'd1;
                    if (n_q == 4'd10) state_d = dat_s ? fail_st : ACK;
                end else if (tmo) begin
                    state_d = fail_st;
                end
            end
            ACK: begin
                if (fall) cnt_d = '0;
                if (clk_s && dat_s) state_d = FINISH;
                else if (tmo && !fall) state_d = fail_st;
            end
            FINISH: begin
                tx_done = 1'b1;
                state_d = IDLE;
            end
            ERROR: begin
                tx_nack = 1'b1;
                state_d = IDLE;
            end
`ifdef PS2_TX_RETRY_EN
            RETRY: begin
                retry_d = 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = INHIBIT;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed + random frames against a behavioural PS/2 device and frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH   = 20;
    localparam int TMO   = 300;
    localparam int H     = 8;
    localparam int BOUND = 3000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_nack, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    int passed = 0, failed = 0, total = 0;
    int cyc = 0, done_cnt = 0, nack_cnt = 0, overlap = 0;
    int done_cyc = -1, rise_cyc = -1;
    logic prev_oe = 1'b0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_nack(tx_nack),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_done) begin done_cnt++; done_cyc = cyc; end
        if (tx_nack) nack_cnt++;
        if ((tx_done && tx_nack) || ((tx_done || tx_nack) && tx_ready)) overlap++;
        if (ps2_clk_oe && !prev_oe) rise_cyc = cyc;
        prev_oe = ps2_clk_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones = 0;
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i+1] = b[i];
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic accept(input logic [7:0] b, input bit hold);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        check("accept_latency", ps2_clk_oe, 1'b1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_start(output int len, output logic sbit, output logic soe);
        int k = 0;
        while (!ps2_clk_oe && k < BOUND) begin @(negedge clk); k++; end
        len = 0;
        while (ps2_clk_oe && len < BOUND) begin len++; @(negedge clk); end
        sbit = ps2_data_in;
        soe  = ps2_data_oe;
    endtask

    task automatic clock_frame(input bit ack, input int stop_at, inout logic [10:0] bits);
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (i == stop_at) return;
            dev_clk = 1'b1;
            if (i <= 10) bits[i] = ps2_data_in;
            if (i == 10 && ack) dev_data = 1'b0;
            if (i == 11) begin repeat (2) @(negedge clk); dev_data = 1'b1; end
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic full_frame(input logic [7:0] b, input string tag);
        int len, d0, n0;
        logic sbit, soe;
        logic [10:0] bits = '1;
        d0 = done_cnt; n0 = nack_cnt;
        accept(b, 1'b0);
        wait_start(len, sbit, soe);
        bits[0] = sbit;
        check({tag, "_inhibit_len"}, len, INH);
        check({tag, "_start_oe"}, soe, 1'b1);
        clock_frame(1'b1, 0, bits);
        repeat (4) @(negedge clk);
        check({tag, "_bits"}, bits, frame_of(b));
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_nack"}, nack_cnt - n0, 0);
        check({tag, "_released"}, {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
    endtask

    initial begin
        int len, d0, n0, k, attempts;
        logic sbit, soe;
        logic [10:0] bits;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_pulses", {tx_done, tx_nack}, 2'b00);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        full_frame(8'hF4, "f4");
        full_frame(8'hED, "ed");
        for (int r = 0; r < 4; r++) full_frame(8'($urandom_range(0, 255)), "rand");

        // device clocks while idle must not disturb the host
        d0 = done_cnt; n0 = nack_cnt;
        for (int i = 0; i < 6; i++) begin
            dev_clk = ~dev_clk;
            repeat (H) @(negedge clk);
        end
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_traffic", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);
        check("idle_pulses", (done_cnt - d0) + (nack_cnt - n0), 0);

        // device never clocks
        d0 = done_cnt; n0 = nack_cnt;
        accept(8'h3C, 1'b0);
        wait_start(len, sbit, soe);
`ifdef PS2_TX_RETRY_EN
        check("tmo_first_no_nack", nack_cnt - n0, 0);
        wait_start(len, sbit, soe);
        check("tmo_retry_inhibit", len, INH);
`endif
        k = 0;
        while (!tx_nack && k < TMO + 20) begin @(negedge clk); k++; end
        check("tmo_window", (k >= TMO && k <= TMO + 2), 1'b1);
        @(negedge clk);
        check("tmo_nack", nack_cnt - n0, 1);
        check("tmo_done", done_cnt - d0, 0);

        // no ack on the 11th clock
        d0 = done_cnt; n0 = nack_cnt;
`ifdef PS2_TX_RETRY_EN
        attempts = 2;
`else
        attempts = 1;
`endif
        accept(8'h5A, 1'b0);
        for (int a = 0; a < attempts; a++) begin
            bits = '1;
            wait_start(len, sbit, soe);
            clock_frame(1'b0, 0, bits);
        end
        repeat (4) @(negedge clk);
        check("noack_nack", nack_cnt - n0, 1);
        check("noack_done", done_cnt - d0, 0);
        check("noack_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // reset after the 5th falling edge
        d0 = done_cnt; n0 = nack_cnt;
        bits = '1;
        accept(8'hF4, 1'b0);
        wait_start(len, sbit, soe);
        clock_frame(1'b1, 5, bits);
        reset_n = 1'b0;
        #1;
        check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", tx_ready, 1'b1);
        check("rst_mid_pulses", (done_cnt - d0) + (nack_cnt - n0), 0);
        full_frame(8'hF4, "post_rst");

        // tx_valid held high while the byte changes after acceptance
        d0 = done_cnt;
        bits = '1;
        accept(8'hAA, 1'b1);
        tx_data = 8'h55;
        wait_start(len, sbit, soe);
        bits[0] = sbit;
        clock_frame(1'b1, 0, bits);
        tx_valid = 1'b0;
        check("hold_bits", bits, frame_of(8'hAA));
        check("hold_done", done_cnt - d0, 1);
        check("hold_b2b_gap", rise_cyc - done_cyc, 2);
        bits = '1;
        wait_start(len, sbit, soe);
        bits[0] = sbit;
        clock_frame(1'b1, 0, bits);
        repeat (30) @(negedge clk);
        check("hold_second_bits", bits, frame_of(8'h55));
        check("hold_second_done", done_cnt - d0, 2);
        check("hold_no_third", {tx_ready, ps2_clk_oe}, 2'b10);

        check("pulse_overlap", overlap, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
